phase_change_monitor: RTL and testbench
=======================================

# phase_change_monitor

Multi-channel phase-change detector for the neuron control block. Each cycle it compares every oscillator's quantised phase against that oscillator's previous sample. For each channel it flags a change and its direction, with modular wrap-around. It also keeps a saturating total of change events and raises a network-stable flag once no oscillator has moved for a programmable number of cycles. The control FSM uses this flag as the ONN convergence indicator.

## Interface
- N_CH, 8, number of oscillator channels
- PH_W, 4, phase word width per channel (phase is modulo 2^PH_W)
- STABLE_CYCLES, 16, consecutive quiet enabled cycles required for `stable`; must be ≥1
- CNT_W, 8, width of `change_count`
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  sample enable; when low the block holds its history
- clear  in  1  synchronous clear; takes priority over `en`
- phase  in  N_CH*PH_W  packed phases; channel i occupies bits [i*PH_W +: PH_W]
- changed  out  N_CH  per-channel change pulse, registered
- dir_adv  out  N_CH  per-channel direction: 1 = phase advanced, valid only where `changed`=1
- any_changed  out  1  OR of `changed`, registered
- change_count  out  CNT_W  saturating count of channel-change events since reset/clear
- stable  out  1  high once STABLE_CYCLES consecutive enabled cycles with no change

## Operation
- State held:
  - prev[N_CH] phase registers.
  - `primed` bit.
  - quiet counter, width clog2(STABLE_CYCLES+1).
  - Output registers.
- Reset (rst_n=0, async) and clear (clear=1 at edge) give:
  - All outputs 0.
  - prev = 0, primed = 0, quiet = 0.
- Priming cycle (en=1, primed=0):
  - prev ← phase, primed ← 1.
  - changed/dir_adv/any_changed ← 0.
  - quiet is not incremented.
  - No change is ever reported on the first sample.
- Compare cycle (en=1, primed=1), per channel i:
  - d = (phase_i − prev_i) mod 2^PH_W.
  - changed_i ← (d≠0).
  - dir_adv_i ← (d≠0) && (d < 2^(PH_W−1)).
  - d = 2^(PH_W−1) (exact half-turn) gives dir_adv=0.
  - prev_i ← phase_i.
- Wrap-around examples (PH_W=4):
  - 15→0: d=1, advance.
  - 0→15: d=15, retard.
- change_count ← min(change_count + popcount(changed_next), 2^CNT_W−1). Once saturated it stays saturated until clear or reset.
- Quiet counter, on compare cycles:
  - Any change: quiet ← 0.
  - No change: quiet ← min(quiet+1, STABLE_CYCLES).
- stable ← (quiet_next == STABLE_CYCLES). It drops in the same cycle as the change that breaks quiet.
- Hold (en=0):
  - changed, dir_adv and any_changed ← 0.
  - prev, primed, quiet, change_count and stable hold.
  - Phase movement while en=0 is caught on the next enabled compare, as one change against the held prev.
- clear and en both high: clear wins. The next enabled cycle is a priming cycle.

## Timing
- Latency is 1 cycle. A phase differing from prev at rising edge k gives changed/dir_adv/any_changed high from edge k until edge k+1.
- A channel changing on every cycle holds `changed` high continuously. Otherwise `changed` is a single-cycle pulse.
- change_count updates at the same edge as `changed`.
- stable rises exactly STABLE_CYCLES enabled compare cycles after the last change edge. Disabled cycles do not count.
- Async reset mid-operation:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After rst_n deasserts, the first enabled edge is a priming cycle.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use N_CH=4, PH_W=4, STABLE_CYCLES=4, CNT_W=4.
- **Priming:** release reset, en=1, phase=0x3A71 held.
  - First edge: changed=0, change_count=0.
  - Four edges after priming: stable=1.
- **Single change with wrap:** primed with ch0=15, then ch0→0.
  - changed=0001, dir_adv[0]=1, any_changed=1 for exactly one cycle.
  - change_count=1, stable=0.
- **Retard and half-turn:**
  - ch1 goes 0→15: changed[1]=1, dir_adv[1]=0.
  - ch2 goes 2→10: changed[2]=1, dir_adv[2]=0.
- **Multi-channel and saturation:** all 4 channels change on 4 consecutive edges.
  - change_count goes 4, 8, 12, 15, then holds at 15 on further changes.
- **Enable hold:** with en=0, move ch3 from 5→7→9.
  - No pulses while disabled; quiet and stable frozen.
  - Re-enable: one pulse, changed[3]=1, dir_adv[3]=1 (d=4).
- **Clear and reset mid-operation:**
  - clear=1 together with en=1 while stable=1: next cycle all outputs 0, the following enabled edge primes, no spurious change.
  - Drop rst_n asynchronously mid-cycle: outputs are 0 before the next edge.

Source files
------------

// File: rtl/phase_change_monitor.sv
// Per-channel phase-change detector with modular direction, saturating event
// count and a network-stable flag raised after a programmable quiet interval.
module phase_change_monitor #(
    parameter int N_CH          = 8,
    parameter int PH_W          = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clear,
    input  logic [N_CH*PH_W-1:0]   phase,
    output logic [N_CH-1:0]        changed,
    output logic [N_CH-1:0]        dir_adv,
    output logic                   any_changed,
    output logic [CNT_W-1:0]       change_count,
    output logic                   stable
);

    localparam int Q_W   = $clog2(STABLE_CYCLES + 1);
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [Q_W-1:0]   Q_MAX   = Q_W'(STABLE_CYCLES);
    localparam logic [SUM_W-1:0] CNT_SAT = SUM_W'({CNT_W{1'b1}});

    logic [N_CH*PH_W-1:0]       prev;
    logic                       primed;
    logic [Q_W-1:0]             quiet;

    logic [N_CH-1:0][PH_W-1:0]  diff;
    logic [N_CH-1:0]            chg_next;
    logic [N_CH-1:0]            adv_next;
    logic [PC_W-1:0]            pop;
    logic [SUM_W-1:0]           sum;
    logic [CNT_W-1:0]           cnt_next;
    logic [Q_W-1:0]             quiet_next;

    // Modular difference: the top bit of d separates advance from retard,
    // so the exact half-turn falls on the retard side.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign diff[i]     = phase[i*PH_W +: PH_W] - prev[i*PH_W +: PH_W];
        assign chg_next[i] = |diff[i];
        assign adv_next[i] = (|diff[i]) & ~diff[i][PH_W-1];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + PC_W'(chg_next[i]);
        end
        sum      = SUM_W'(change_count) + SUM_W'(pop);
        cnt_next = (sum > CNT_SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        if (|chg_next) begin
            quiet_next = '0;
        end else if (quiet < Q_MAX) begin
            quiet_next = quiet + 1'b1;
        end else begin
            quiet_next = quiet;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev         <= '0;
            primed       <= 1'b0;
            quiet        <= '0;
            changed      <= '0;
            dir_adv      <= '0;
            any_changed  <= 1'b0;
            change_count <= '0;
            stable       <= 1'b0;
        end else if (clear) begin
            prev         <= '0;
            primed       <= 1'b0;
            quiet        <= '0;
            changed      <= '0;
            dir_adv      <= '0;
            any_changed  <= 1'b0;
            change_count <= '0;
            stable       <= 1'b0;
        end else if (en && !primed) begin
            prev        <= phase;
            primed      <= 1'b1;
            changed     <= '0;
            dir_adv     <= '0;
            any_changed <= 1'b0;
        end else if (en) begin
            prev         <= phase;
            changed      <= chg_next;
            dir_adv      <= adv_next;
            any_changed  <= |chg_next;
            change_count <= cnt_next;
            quiet        <= quiet_next;
            stable       <= (quiet_next == Q_MAX);
        end else begin
            changed     <= '0;
            dir_adv     <= '0;
            any_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_change_monitor.sv
// Directed bench for phase_change_monitor with N_CH=4, PH_W=4,
// STABLE_CYCLES=4, CNT_W=4; expected values are hand-computed per vector.
module tb_phase_change_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic [15:0] phase;
    logic [3:0]  changed;
    logic [3:0]  dir_adv;
    logic        any_changed;
    logic [3:0]  change_count;
    logic        stable;

    int n_tests = 0;
    int n_fail  = 0;

    phase_change_monitor #(
        .N_CH(4), .PH_W(4), .STABLE_CYCLES(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .phase(phase),
        .changed(changed), .dir_adv(dir_adv), .any_changed(any_changed),
        .change_count(change_count), .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_chg,
                              input logic [3:0] e_dir, input logic [3:0] e_cnt,
                              input logic e_stb);
        chk({tag, ".changed"}, 32'(changed), 32'(e_chg));
        chk({tag, ".dir_adv"}, 32'(dir_adv), 32'(e_dir));
        chk({tag, ".any"}, 32'(any_changed), 32'(|e_chg));
        chk({tag, ".count"}, 32'(change_count), 32'(e_cnt));
        chk({tag, ".stable"}, 32'(stable), 32'(e_stb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        phase = 16'h0000;
        #3;
        check_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0);
        #9;
        rst_n = 1'b1;

        // Priming and quiet run-up to stable
        en = 1'b1; phase = 16'h3A71;
        step(); check_outs("prime", 4'h0, 4'h0, 4'h0, 1'b0);
        step(); chk("quiet1.stable", 32'(stable), 32'd0);
        step(); chk("quiet2.stable", 32'(stable), 32'd0);
        step(); chk("quiet3.stable", 32'(stable), 32'd0);
        step(); check_outs("quiet4", 4'h0, 4'h0, 4'h0, 1'b1);

        // ch0 1->15 (retard, d=14), then wrap 15->0 (advance, d=1)
        phase = 16'h3A7F;
        step(); check_outs("ch0_1to15", 4'h1, 4'h0, 4'h1, 1'b0);
        step(); check_outs("ch0_hold", 4'h0, 4'h0, 4'h1, 1'b0);
        phase = 16'h3A70;
        step(); check_outs("ch0_wrap", 4'h1, 4'h1, 4'h2, 1'b0);
        step(); check_outs("ch0_pulse_end", 4'h0, 4'h0, 4'h2, 1'b0);

        // Retard and half-turn
        phase = 16'h3A00;
        step(); check_outs("ch1_7to0", 4'h2, 4'h0, 4'h3, 1'b0);
        phase = 16'h3AF0;
        step(); check_outs("ch1_0to15", 4'h2, 4'h0, 4'h4, 1'b0);
        phase = 16'h32F0;
        step(); check_outs("ch2_10to2", 4'h4, 4'h0, 4'h5, 1'b0);
        phase = 16'h3AF0;
        step(); check_outs("ch2_2to10", 4'h4, 4'h0, 4'h6, 1'b0);

        // Clear, re-prime, then multi-channel saturation
        clear = 1'b1;
        step(); check_outs("clear1", 4'h0, 4'h0, 4'h0, 1'b0);
        clear = 1'b0; phase = 16'h0000;
        step(); check_outs("reprime1", 4'h0, 4'h0, 4'h0, 1'b0);
        phase = 16'h1111;
        step(); check_outs("multi1", 4'hF, 4'hF, 4'h4, 1'b0);
        phase = 16'h2222;
        step(); check_outs("multi2", 4'hF, 4'hF, 4'h8, 1'b0);
        phase = 16'h0000;
        step(); check_outs("multi3", 4'hF, 4'h0, 4'hC, 1'b0);
        phase = 16'h8888;
        step(); check_outs("multi4_sat", 4'hF, 4'h0, 4'hF, 1'b0);
        phase = 16'h9999;
        step(); check_outs("multi5_sat", 4'hF, 4'hF, 4'hF, 1'b0);
        step(); check_outs("multi_hold", 4'h0, 4'h0, 4'hF, 1'b0);

        // Enable hold: ch3 5 -> 7 -> 9 while disabled
        phase = 16'h5999;
        step(); check_outs("ch3_to5", 4'h8, 4'h0, 4'hF, 1'b0);
        step(); step();
        en = 1'b0; phase = 16'h7999;
        step(); check_outs("dis_7", 4'h0, 4'h0, 4'hF, 1'b0);
        phase = 16'h9999;
        step(); check_outs("dis_9", 4'h0, 4'h0, 4'hF, 1'b0);
        step(); step(); step();
        chk("dis_frozen.stable", 32'(stable), 32'd0);
        en = 1'b1;
        step(); check_outs("reen_ch3", 4'h8, 4'h8, 4'hF, 1'b0);
        step(); step(); step();
        chk("reen_q3.stable", 32'(stable), 32'd0);
        step(); check_outs("reen_stable", 4'h0, 4'h0, 4'hF, 1'b1);

        // clear with en while stable, then priming against a fresh phase
        clear = 1'b1;
        step(); check_outs("clear2", 4'h0, 4'h0, 4'h0, 1'b0);
        clear = 1'b0; phase = 16'h1234;
        step(); check_outs("reprime2", 4'h0, 4'h0, 4'h0, 1'b0);
        step(); check_outs("reprime2_q", 4'h0, 4'h0, 4'h0, 1'b0);
        phase = 16'h1235;
        step(); check_outs("post_clear_chg", 4'h1, 4'h1, 4'h1, 1'b0);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 4'h0, 4'h0, 4'h0, 1'b0);
        step();
        #2 rst_n = 1'b1;
        step(); check_outs("rst_reprime", 4'h0, 4'h0, 4'h0, 1'b0);
        phase = 16'h1236;
        step(); check_outs("rst_post_chg", 4'h1, 4'h1, 4'h1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
